johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_pkg.sv | 22 ++
 rtl/johnson_code_lut.sv | 30 +++
 rtl/johnson_decoder.sv | 138 +++++++++++++
 tb/tb_johnson_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code decoder: FSM state encoding
// and the successor function that defines the legal code sequence.
package johnson_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Widest code the helper handles; callers cast in and out at their width.
  localparam int MAX_W = 32;

  // Successor of a Johnson code of the given width: shift right, feed back ~lsb.
  function automatic logic [MAX_W-1:0] johnson_next(input logic [MAX_W-1:0] code,
                                                    input int width);
    logic [MAX_W-1:0] r;
    r = code >> 1;
    if (!code[0]) r = r | (MAX_W'(1) << (width - 1));
    return r;
  endfunction

endpackage

// File: rtl/johnson_code_lut.sv
// Combinational code-to-position map: walks the 2*WIDTH sequence from 0 and
// reports whether the input appears in it and at which position.
module johnson_code_lut
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]              code_i,
  output logic                          legal_o,
  output logic [$clog2(2*WIDTH)-1:0]    index_o
);

  localparam int IDX_W = $clog2(2*WIDTH);

  logic [WIDTH-1:0] c;

  always_comb begin
    legal_o = 1'b0;
    index_o = '0;
    c       = '0;
    for (int k = 0; k < 2*WIDTH; k++) begin
      if (code_i == c) begin
        legal_o = 1'b1;
        index_o = IDX_W'(k);
      end
      c = WIDTH'(johnson_next(MAX_W'(c), WIDTH));
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code position decoder with sequence lock tracking and a saturating
// error counter; all outputs are registered one clock after the sample edge.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              jc_in,
  input  logic                          jc_valid,
  input  logic                          clr_err,
  output logic [$clog2(2*WIDTH)-1:0]    index,
  output logic                          index_valid,
  output logic                          illegal,
  output logic                          seq_err,
  output logic                          locked,
  output logic [ERR_W-1:0]              err_count
);

  localparam int IDX_W = $clog2(2*WIDTH);
  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] LOCK_CNT = RUN_W'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             iv_q, iv_d;
  logic             ill_q, ill_d;
  logic             seq_q, seq_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             lut_legal;
  logic [IDX_W-1:0] lut_idx;
  logic [WIDTH-1:0] succ;
  logic             is_succ;
  logic [RUN_W-1:0] run_inc;

  johnson_code_lut #(.WIDTH(WIDTH)) u_lut (
    .code_i  (jc_in),
    .legal_o (lut_legal),
    .index_o (lut_idx)
  );

  assign succ    = WIDTH'(johnson_next(MAX_W'(prev_q), WIDTH));
  assign is_succ = prev_vld_q && (jc_in == succ);
  assign run_inc = run_q + RUN_W'(1);

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    index_d    = index_q;
    iv_d       = 1'b0;
    ill_d      = 1'b0;
    seq_d      = 1'b0;
    err_d      = err_q;
    if (jc_valid) begin
      if (!lut_legal) begin
        // An illegal code breaks any chain; the next legal sample starts fresh.
        ill_d      = 1'b1;
        state_d    = SEARCH;
        run_d      = '0;
        prev_vld_d = 1'b0;
      end else begin
        index_d    = lut_idx;
        iv_d       = 1'b1;
        prev_d     = jc_in;
        prev_vld_d = 1'b1;
        case (state_q)
          SEARCH: begin
            if (is_succ) begin
              if (run_inc >= LOCK_CNT) begin
                state_d = LOCKED;
                run_d   = '0;
              end else begin
                run_d = run_inc;
              end
            end else begin
              run_d = '0;
            end
          end
          LOCKED: begin
            // Advance, stall, or counter reset to code 0 are all acceptable.
            if (!(is_succ || (jc_in == prev_q) || (jc_in == '0))) begin
              seq_d   = 1'b1;
              state_d = SEARCH;
              run_d   = '0;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
    if (clr_err)
      err_d = '0;
    else if ((ill_d || seq_d) && (err_q != ERR_MAX))
      err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      run_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      index_q    <= '0;
      iv_q       <= 1'b0;
      ill_q      <= 1'b0;
      seq_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      index_q    <= index_d;
      iv_q       <= iv_d;
      ill_q      <= ill_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
    end
  end

  assign index       = index_q;
  assign index_valid = iv_q;
  assign illegal     = ill_q;
  assign seq_err     = seq_q;
  assign locked      = (state_q == LOCKED);
  assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (WIDTH=4, LOCK_N=2, ERR_W=2): directed
// samples push hand-computed responses, a negedge monitor pops and compares.
module tb_johnson_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] jc_in;
  logic       jc_valid;
  logic       clr_err;
  logic [2:0] index;
  logic       index_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [1:0] err_count;

  typedef struct packed {
    logic       iv;
    logic [2:0] idx;
    logic       ill;
    logic       seq;
    logic       lck;
    logic [1:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic pending = 1'b0;

  johnson_decoder #(.WIDTH(4), .LOCK_N(2), .ERR_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .jc_in       (jc_in),
    .jc_valid    (jc_valid),
    .clr_err     (clr_err),
    .index       (index),
    .index_valid (index_valid),
    .illegal     (illegal),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) pending <= jc_valid && !rst;

  always @(negedge clk) begin
    exp_t e;
    if (pending) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("index_valid", int'(index_valid), int'(e.iv));
        chk("index",       int'(index),       int'(e.idx));
        chk("illegal",     int'(illegal),     int'(e.ill));
        chk("seq_err",     int'(seq_err),     int'(e.seq));
        chk("locked",      int'(locked),      int'(e.lck));
        chk("err_count",   int'(err_count),   int'(e.err));
      end
    end else if (!rst) begin
      chk("idle_pulses", int'({index_valid, illegal, seq_err}), 0);
    end
  end

  task automatic send(input logic [3:0] code, input logic clr, input logic iv,
                      input int idx, input logic ill, input logic seq,
                      input logic lck, input int err);
    exp_t e;
    @(posedge clk);
    #1;
    jc_in    = code;
    jc_valid = 1'b1;
    clr_err  = clr;
    e.iv  = iv;
    e.idx = idx[2:0];
    e.ill = ill;
    e.seq = seq;
    e.lck = lck;
    e.err = err[1:0];
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    jc_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_index"},       int'(index),       0);
    chk({tag, "_index_valid"}, int'(index_valid), 0);
    chk({tag, "_illegal"},     int'(illegal),     0);
    chk({tag, "_seq_err"},     int'(seq_err),     0);
    chk({tag, "_locked"},      int'(locked),      0);
    chk({tag, "_err_count"},   int'(err_count),   0);
  endtask

  initial begin
    rst      = 1'b1;
    jc_in    = 4'b0000;
    jc_valid = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);
    chk_reset("rst0");
    @(posedge clk);
    #1 rst = 1'b0;

    // Acquire lock, then walk the full sequence
    send(4'b0000, 0, 1, 0, 0, 0, 0, 0);
    send(4'b1000, 0, 1, 1, 0, 0, 0, 0);
    send(4'b1100, 0, 1, 2, 0, 0, 1, 0);
    send(4'b1110, 0, 1, 3, 0, 0, 1, 0);
    send(4'b1111, 0, 1, 4, 0, 0, 1, 0);
    send(4'b0111, 0, 1, 5, 0, 0, 1, 0);
    send(4'b0011, 0, 1, 6, 0, 0, 1, 0);
    send(4'b0001, 0, 1, 7, 0, 0, 1, 0);
    // Wrap, advance, stall
    send(4'b0000, 0, 1, 0, 0, 0, 1, 0);
    send(4'b1000, 0, 1, 1, 0, 0, 1, 0);
    send(4'b1000, 0, 1, 1, 0, 0, 1, 0);
    idle();
    // Illegal while locked: index holds
    send(4'b0101, 0, 0, 1, 1, 0, 0, 1);
    // Relock, then jump to a non-successor
    send(4'b0000, 0, 1, 0, 0, 0, 0, 1);
    send(4'b1000, 0, 1, 1, 0, 0, 0, 1);
    send(4'b1100, 0, 1, 2, 0, 0, 1, 1);
    send(4'b1111, 0, 1, 4, 0, 1, 0, 2);
    // Successors in SEARCH relock; clr_err wins over nothing-to-count
    send(4'b0111, 0, 1, 5, 0, 0, 0, 2);
    send(4'b0011, 1, 1, 6, 0, 0, 1, 0);
    // Saturation at 3, then clear coincident with an illegal sample
    send(4'b0101, 0, 0, 6, 1, 0, 0, 1);
    send(4'b1010, 0, 0, 6, 1, 0, 0, 2);
    send(4'b1001, 0, 0, 6, 1, 0, 0, 3);
    send(4'b1011, 0, 0, 6, 1, 0, 0, 3);
    send(4'b1101, 0, 0, 6, 1, 0, 0, 3);
    send(4'b0100, 1, 0, 6, 1, 0, 0, 0);
    // Relock ahead of the asynchronous reset
    send(4'b0000, 0, 1, 0, 0, 0, 0, 0);
    send(4'b1000, 0, 1, 1, 0, 0, 0, 0);
    send(4'b1100, 0, 1, 2, 0, 0, 1, 0);
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    // First sample after reset has no predecessor, so lock needs two more
    send(4'b1100, 0, 1, 2, 0, 0, 0, 0);
    send(4'b1110, 0, 1, 3, 0, 0, 0, 0);
    send(4'b1111, 0, 1, 4, 0, 0, 1, 0);
    idle();
    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
